// File: rtl/rob_unit.sv
// In-order-commit reorder buffer sitting behind rename; returns displaced PRNs
// to the free list at retirement and drops everything on flush.
module rob_unit #(
  parameter int NUM_ENTRIES = 16,
  parameter int A_REG_W     = 5,
  parameter int P_REG_W     = 6,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alloc_valid,
  output logic               alloc_ready,
  input  logic               alloc_has_dest,
  input  logic [A_REG_W-1:0] alloc_areg,
  input  logic [P_REG_W-1:0] alloc_new_prn,
  input  logic [P_REG_W-1:0] alloc_old_prn,
  output logic [IDX_W-1:0]   alloc_idx,
  input  logic               cmpl_valid,
  input  logic [IDX_W-1:0]   cmpl_idx,
  output logic               commit_valid,
  input  logic               commit_ready,
  output logic               commit_has_dest,
  output logic [A_REG_W-1:0] commit_areg,
  output logic [P_REG_W-1:0] commit_new_prn,
  output logic [P_REG_W-1:0] commit_old_prn,
  input  logic               flush,
  output logic [IDX_W:0]     count,
  output logic               empty,
  output logic               full
);

  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(NUM_ENTRIES);

  logic [IDX_W-1:0]       head;
  logic [IDX_W-1:0]       tail;
  logic [IDX_W:0]         count_q;
  logic [NUM_ENTRIES-1:0] valid_q;
  logic [NUM_ENTRIES-1:0] done_q;

  logic               has_dest_q [NUM_ENTRIES];
  logic [A_REG_W-1:0] areg_q     [NUM_ENTRIES];
  logic [P_REG_W-1:0] new_prn_q  [NUM_ENTRIES];
  logic [P_REG_W-1:0] old_prn_q  [NUM_ENTRIES];

  logic alloc_fire;
  logic commit_fire;
  logic cmpl_hit;

  // Full/empty come from the occupancy counter only; head==tail is ambiguous.
  assign full        = (count_q == FULL_COUNT);
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign alloc_ready = !full;
  assign alloc_idx   = tail;

  assign alloc_fire   = alloc_valid && alloc_ready;
  assign commit_valid = !empty && valid_q[head] && done_q[head] && !flush;
  assign commit_fire  = commit_valid && commit_ready;
  // A completion racing the allocation into the same slot is stale.
  assign cmpl_hit     = cmpl_valid && valid_q[cmpl_idx] &&
                        !(alloc_fire && (cmpl_idx == tail));

  assign commit_has_dest = has_dest_q[head];
  assign commit_areg     = areg_q[head];
  assign commit_new_prn  = new_prn_q[head];
  assign commit_old_prn  = old_prn_q[head];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (cmpl_hit) begin
        done_q[cmpl_idx] <= 1'b1;
      end
      if (commit_fire) begin
        valid_q[head] <= 1'b0;
        done_q[head]  <= 1'b0;
        head          <= head + 1'b1;
      end
      if (alloc_fire) begin
        valid_q[tail] <= 1'b1;
        done_q[tail]  <= 1'b0;
        tail          <= tail + 1'b1;
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; valid/done gate every use of it.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && alloc_fire) begin
      has_dest_q[tail] <= alloc_has_dest;
      areg_q[tail]     <= alloc_areg;
      new_prn_q[tail]  <= alloc_new_prn;
      old_prn_q[tail]  <= alloc_old_prn;
    end
  end

  a_alloc_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (alloc_valid && !alloc_ready && !flush) |=>
      (alloc_valid && $stable({alloc_has_dest, alloc_areg, alloc_new_prn, alloc_old_prn})));

endmodule

// File: doc/rob_unit.md
Name: rob_unit

Overview:
Reorder buffer directly downstream of the rename stage.
- Accepts one renamed instruction per cycle: arch dest, new PRN, and the previous (old) PRN it displaced in the RAT.
- Tracks completion by ROB index and commits strictly in program order.
- On commit, returns the old PRN so the free list can reclaim it.
- Flush discards all in-flight entries.

Parameters:
NUM_ENTRIES, 16, ROB depth; must be a power of two.
A_REG_W, 5, arch register index width (32 arch regs).
P_REG_W, 6, physical register index width (48 phys regs).
IDX_W, $clog2(NUM_ENTRIES), ROB index width.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset, sampled on rising clk
alloc_valid  in  1  rename presents an instruction
alloc_ready  out  1  ROB can accept an entry
alloc_has_dest  in  1  instruction writes a register
alloc_areg  in  A_REG_W  arch destination
alloc_new_prn  in  P_REG_W  newly mapped PRN
alloc_old_prn  in  P_REG_W  PRN previously mapped to alloc_areg
alloc_idx  out  IDX_W  ROB index given to the current alloc (equals tail)
cmpl_valid  in  1  execution completion strobe
cmpl_idx  in  IDX_W  ROB index completing
commit_valid  out  1  head entry is done and may retire
commit_ready  in  1  downstream accepts the commit
commit_has_dest  out  1  head entry writes a register
commit_areg  out  A_REG_W  head arch dest
commit_new_prn  out  P_REG_W  head new PRN (architectural state)
commit_old_prn  out  P_REG_W  PRN to return to the free list when commit_has_dest
flush  in  1  discard all entries
count  out  IDX_W+1  occupied entries
empty  out  1  count == 0
full  out  1  count == NUM_ENTRIES

Behaviour:
- State:
  - head, tail: IDX_W bits, wrap modulo NUM_ENTRIES.
  - count: IDX_W+1 bits.
  - Per entry: valid, done, has_dest, areg, new_prn, old_prn.
- Reset (rst_n low at rising clk):
  - head = tail = count = 0; all valid/done cleared.
  - Outputs after reset: alloc_ready=1, commit_valid=0, empty=1, full=0, count=0, alloc_idx=0.
  - Payload outputs are don't-care while commit_valid=0.
- alloc_ready = !full, from registered count only.
  - No same-cycle bypass from a commit freeing space.
- Alloc fire (alloc_valid && alloc_ready):
  - Entry[tail] is written with valid=1, done=0, and the payload.
  - tail increments next cycle.
- alloc_idx = tail, combinational from state.
  - Rename/dispatch captures it in the same cycle as the fire.
- Completion (cmpl_valid):
  - If entry[cmpl_idx].valid, set done=1 next cycle.
  - Completion to an invalid entry is ignored, with no state change.
  - Completion to the slot being allocated in the same cycle is ignored; the allocation wins and done=0.
- commit_valid = !empty && entry[head].valid && entry[head].done && !flush.
  - commit_* payload outputs are driven combinationally from entry[head].
- Commit fire (commit_valid && commit_ready):
  - entry[head].valid and done are cleared; head increments next cycle.
  - At most one commit per cycle.
  - Completion latency: a cmpl strobe to the head in cycle N gives earliest commit_valid in cycle N+1.
- count update:
  - +1 on alloc fire only.
  - -1 on commit fire only.
  - Unchanged when both fire in the same cycle, including when count is 1 or 15.
- Full with simultaneous commit: alloc_ready stays 0 that cycle, so only the commit occurs.
- Flush (highest priority after reset):
  - Same effect as reset on next cycle: head=tail=count=0, all valid/done cleared.
  - Alloc, completion, and commit in the flush cycle are ignored; commit_valid is forced 0.
  - No old PRNs are returned. The rename stage owns RAT/free-list recovery.
- Wrap-around: after NUM_ENTRIES allocations, tail returns to 0. Full/empty are disambiguated by count, never by pointer equality.
- Assertions:
  - alloc_valid && !alloc_ready must hold payload stable.
  - commit_ready may toggle freely.

Test Plan:
1. Reset → alloc_ready=1, empty=1, count=0, commit_valid=0. Alloc areg=3/new=32/old=3 → alloc_idx=0; next cycle count=1, commit_valid=0.
2. Alloc idx0, idx1, idx2; complete idx2 then idx0 → commit_valid rises only after idx0 done. Commits occur in order 0 then (after cmpl idx1) 1, 2. commit_old_prn matches each entry's old PRN.
3. Allocate 16 with no commits → full=1, alloc_ready=0, count=16. The 17th alloc_valid is held; complete and commit idx0 → alloc_ready=1 the following cycle and the 17th alloc gets alloc_idx=0 (wrap).
4. count=5, head done, alloc and commit fire in the same cycle → count stays 5, head+1, tail+1.
5. Eight entries in flight, some done; assert flush with alloc_valid and commit_ready high → next cycle count=0, empty=1, head=tail=0, no commit fired, and earlier done bits do not reappear after re-allocation.
6. cmpl_valid to an unallocated idx 9 → no state change. Later alloc into idx 9 shows done=0 (commit_valid stays 0 until a real completion). rst_n low mid-stream → same state as test 1.
